// File: rtl/servo_if.sv
// Servo loop control bus: sequencer <-> PWM / ADC / PID / current monitor.
// The sequencer connects as slave; the surrounding loop drives the master side.
interface servo_if #(
   parameter int unsigned DUTY_W = 18
);
   logic              enable;
   logic              period_end;
   logic              adc_done;
   logic              pid_valid;
   logic [DUTY_W-1:0] pid_duty;
   logic              current_high;
   logic              clear_lockout;
   logic              adc_start;
   logic              pid_en;
   logic              pid_clr;
   logic [DUTY_W-1:0] duty_cmd;
   logic              duty_load;
   logic              fault;
   logic              lockout;
   logic [2:0]        state;

   modport master (
      output enable, period_end, adc_done, pid_valid, pid_duty, current_high, clear_lockout,
      input  adc_start, pid_en, pid_clr, duty_cmd, duty_load, fault, lockout, state
   );

   modport slave (
      input  enable, period_end, adc_done, pid_valid, pid_duty, current_high, clear_lockout,
      output adc_start, pid_en, pid_clr, duty_cmd, duty_load, fault, lockout, state
   );
endinterface

// File: rtl/servo_sequencer.sv
// Per-PWM-period sequencer: sample -> PID step -> saturate -> load at next
// boundary, with over-current trip, cooldown, bounded retries and lockout.
module servo_sequencer #(
   parameter int unsigned DUTY_W          = 18,
   parameter int unsigned DUTY_MAX        = 2**18-1,
   parameter int unsigned ADC_TIMEOUT     = 255,
   parameter int unsigned PID_TIMEOUT     = 63,
   parameter int unsigned COOLDOWN_CYCLES = 1000,
   parameter int unsigned MAX_RETRIES     = 3,
   parameter int unsigned GOOD_PERIODS    = 16
) (
   input  logic     clk,
   input  logic     rst,
   servo_if.slave   bus
);
   localparam int unsigned TMR_MAX = (ADC_TIMEOUT > PID_TIMEOUT) ? ADC_TIMEOUT : PID_TIMEOUT;
   localparam int TMR_W  = $clog2(TMR_MAX + 1);
   localparam int COOL_W = $clog2(COOLDOWN_CYCLES + 1);
   localparam int RTY_W  = $clog2(MAX_RETRIES + 2);
   localparam int GOOD_W = $clog2(GOOD_PERIODS + 1);

   localparam logic [DUTY_W-1:0] DMAX      = DUTY_W'(DUTY_MAX);
   localparam logic [TMR_W-1:0]  ADC_LAST  = TMR_W'(ADC_TIMEOUT - 1);
   localparam logic [TMR_W-1:0]  PID_LAST  = TMR_W'(PID_TIMEOUT - 1);
   localparam logic [COOL_W-1:0] COOL_INIT = COOL_W'(COOLDOWN_CYCLES);
   localparam logic [RTY_W-1:0]  RTY_SAT   = RTY_W'(MAX_RETRIES + 1);
   localparam logic [RTY_W-1:0]  RTY_LIM   = RTY_W'(MAX_RETRIES);
   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_PERIODS - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SAMPLE  = 3'd1,
      S_COMPUTE = 3'd2,
      S_WAIT    = 3'd3,
      S_FAULT   = 3'd4,
      S_LOCKOUT = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [DUTY_W-1:0]   duty_q, duty_d, held_q, held_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [COOL_W-1:0]   cool_q, cool_d;
   logic [RTY_W-1:0]    retry_q, retry_d, retry_inc;
   logic [GOOD_W-1:0]   good_q, good_d;
   logic                adc_start_q, adc_start_d, pid_en_q, pid_en_d;
   logic                pid_clr_q, pid_clr_d, duty_load_q, duty_load_d;
   logic                fault_q, lockout_q;
   logic                trip, stop;

   // Next-state and next-output decode; trip/stop are applied last because
   // over-current and enable loss override whatever the state proposed.
   always_comb begin
      state_d     = state_q;
      duty_d      = duty_q;
      held_d      = held_q;
      timer_d     = '0;
      cool_d      = cool_q;
      retry_d     = retry_q;
      good_d      = good_q;
      adc_start_d = 1'b0;
      pid_en_d    = 1'b0;
      pid_clr_d   = 1'b0;
      duty_load_d = 1'b0;
      trip        = 1'b0;
      stop        = 1'b0;
      retry_inc   = (retry_q == RTY_SAT) ? retry_q : retry_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            duty_d = '0;
            if (bus.current_high) trip = 1'b1;
            else if (bus.enable && bus.period_end) begin
               state_d     = S_SAMPLE;
               adc_start_d = 1'b1;
            end
         end
         S_SAMPLE: begin
            timer_d = timer_q + 1'b1;
            if (bus.current_high) trip = 1'b1;
            else if (!bus.enable) stop = 1'b1;
            else if (bus.adc_done) begin
               state_d  = S_COMPUTE;
               pid_en_d = 1'b1;
               timer_d  = '0;
            end
            else if (timer_q == ADC_LAST) trip = 1'b1;
         end
         S_COMPUTE: begin
            timer_d = timer_q + 1'b1;
            if (bus.current_high) trip = 1'b1;
            else if (!bus.enable) stop = 1'b1;
            else if (bus.pid_valid) begin
               held_d  = (bus.pid_duty > DMAX) ? DMAX : bus.pid_duty;
               state_d = S_WAIT;
               timer_d = '0;
            end
            else if (timer_q == PID_LAST) trip = 1'b1;
         end
         S_WAIT: begin
            if (bus.current_high) trip = 1'b1;
            else if (!bus.enable) stop = 1'b1;
            else if (bus.period_end) begin
               // Load this period's duty and start the next sample together.
               duty_d      = held_q;
               duty_load_d = 1'b1;
               adc_start_d = 1'b1;
               state_d     = S_SAMPLE;
               if (good_q >= GOOD_LAST) begin
                  good_d  = '0;
                  retry_d = '0;
               end else begin
                  good_d = good_q + 1'b1;
               end
            end
         end
         S_FAULT: begin
            duty_d = '0;
            if (bus.current_high) cool_d = COOL_INIT;
            else if (cool_q <= COOL_W'(1)) begin
               cool_d  = '0;
               state_d = S_IDLE;
            end
            else cool_d = cool_q - 1'b1;
         end
         S_LOCKOUT: begin
            duty_d = '0;
            if (bus.clear_lockout) begin
               state_d = S_IDLE;
               retry_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            duty_d  = '0;
         end
      endcase

      if (trip) begin
         retry_d     = retry_inc;
         state_d     = (retry_inc > RTY_LIM) ? S_LOCKOUT : S_FAULT;
         cool_d      = COOL_INIT;
         duty_d      = '0;
         duty_load_d = 1'b1;
         pid_clr_d   = 1'b1;
         good_d      = '0;
         timer_d     = '0;
      end else if (stop) begin
         state_d     = S_IDLE;
         duty_d      = '0;
         duty_load_d = 1'b1;
         pid_clr_d   = 1'b1;
         good_d      = '0;
         timer_d     = '0;
      end
   end

   // State and output registers; reset emits no pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         duty_q      <= '0;
         held_q      <= '0;
         timer_q     <= '0;
         cool_q      <= '0;
         retry_q     <= '0;
         good_q      <= '0;
         adc_start_q <= 1'b0;
         pid_en_q    <= 1'b0;
         pid_clr_q   <= 1'b0;
         duty_load_q <= 1'b0;
         fault_q     <= 1'b0;
         lockout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         duty_q      <= duty_d;
         held_q      <= held_d;
         timer_q     <= timer_d;
         cool_q      <= cool_d;
         retry_q     <= retry_d;
         good_q      <= good_d;
         adc_start_q <= adc_start_d;
         pid_en_q    <= pid_en_d;
         pid_clr_q   <= pid_clr_d;
         duty_load_q <= duty_load_d;
         fault_q     <= (state_d == S_FAULT) || (state_d == S_LOCKOUT);
         lockout_q   <= (state_d == S_LOCKOUT);
      end
   end

   assign bus.state     = state_q;
   assign bus.duty_cmd  = duty_q;
   assign bus.adc_start = adc_start_q;
   assign bus.pid_en    = pid_en_q;
   assign bus.pid_clr   = pid_clr_q;
   assign bus.duty_load = duty_load_q;
   assign bus.fault     = fault_q;
   assign bus.lockout   = lockout_q;
endmodule

// File: tb/tb_servo_sequencer.sv
// Bench for servo_sequencer: directed vector table, hand-written corner
// sequences, then a randomized run against a transaction-level model.
module tb_servo_sequencer;
   localparam int unsigned DW    = 18;
   localparam logic [17:0] DMAX  = 18'h30000;
   localparam int          COOL  = 10;
   localparam int          MAXR  = 3;
   localparam int          GOODP = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;

   servo_if #(.DUTY_W(DW)) bus ();

   servo_sequencer #(
      .DUTY_W(DW), .DUTY_MAX(32'h30000), .ADC_TIMEOUT(255), .PID_TIMEOUT(63),
      .COOLDOWN_CYCLES(COOL), .MAX_RETRIES(MAXR), .GOOD_PERIODS(GOODP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pe, ad, pv, ch;
      logic [17:0] pd;
      logic [2:0]  st;
      logic        as, pen, pclr, dl;
      logic [17:0] dc;
      logic        f;
   } vec_t;

   function automatic vec_t mk(input logic pe, ad, pv, ch, input logic [17:0] pd,
                               input logic [2:0] st, input logic as, pen, pclr, dl,
                               input logic [17:0] dc, input logic f);
      vec_t v;
      v.pe = pe; v.ad = ad; v.pv = pv; v.ch = ch; v.pd = pd;
      v.st = st; v.as = as; v.pen = pen; v.pclr = pclr; v.dl = dl; v.dc = dc; v.f = f;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
   endtask

   // One clock: inputs already set by caller, sample #1 after the edge,
   // then drop the single-cycle inputs.
   task automatic step();
      @(posedge clk);
      #1;
      bus.period_end    = 1'b0;
      bus.adc_done      = 1'b0;
      bus.pid_valid     = 1'b0;
      bus.current_high  = 1'b0;
      bus.clear_lockout = 1'b0;
   endtask

   task automatic exp_out(input string tag, input logic [2:0] st, input logic as, pen, pclr, dl,
                          input logic [17:0] dc, input logic f, lk);
      chk({tag, ".state"},     bus.state, st);
      chk({tag, ".adc_start"}, bus.adc_start, as);
      chk({tag, ".pid_en"},    bus.pid_en, pen);
      chk({tag, ".pid_clr"},   bus.pid_clr, pclr);
      chk({tag, ".duty_load"}, bus.duty_load, dl);
      chk({tag, ".duty_cmd"},  bus.duty_cmd, dc);
      chk({tag, ".fault"},     bus.fault, f);
      chk({tag, ".lockout"},   bus.lockout, lk);
   endtask

   // Called in the first visible FAULT cycle; counts FAULT cycles (bounded).
   task automatic fault_len(input string tag, input int exp);
      int n;
      n = 0;
      while (bus.state == 3'd4 && n < 5000) begin
         n++;
         step();
      end
      chk({tag, ".fault_cycles"}, n, exp);
      chk({tag, ".idle_after"}, bus.state, 3'd0);
   endtask

   task automatic trip(input string tag, input logic [2:0] exp_st);
      bus.current_high = 1'b1;
      step();
      exp_out(tag, exp_st, 0, 0, 1, 1, 18'h0, 1, exp_st == 3'd5);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        tbl[14];
      int          n;
      logic [17:0] pend[$];
      logic [17:0] m_duty, pid_val, got;
      int          m_cool, retries, good, pe_cnt, adc_cd, pid_cd, lock_wait;
      bit          m_locked;
      logic        pe, ad, pv, inj, clr;
      logic        e_as, e_dl, e_clr;

      bus.enable = 1'b0; bus.period_end = 1'b0; bus.adc_done = 1'b0; bus.pid_valid = 1'b0;
      bus.pid_duty = '0; bus.current_high = 1'b0; bus.clear_lockout = 1'b0;

      // Reset state
      rst = 1'b1;
      step(); step();
      exp_out("reset", 0, 0, 0, 0, 0, 18'h0, 0, 0);
      rst = 1'b0;
      bus.enable = 1'b1;

      // Directed vectors: nominal, saturation, fault-beats-period_end, ignored pid_valid in FAULT
      //            pe ad pv ch pd        st as pen clr dl dc        f
      tbl[0]  = mk(0, 0, 0, 0, 18'h0,     0, 0, 0, 0, 0, 18'h0,     0);
      tbl[1]  = mk(1, 0, 0, 0, 18'h0,     1, 1, 0, 0, 0, 18'h0,     0);
      tbl[2]  = mk(0, 0, 0, 0, 18'h0,     1, 0, 0, 0, 0, 18'h0,     0);
      tbl[3]  = mk(0, 1, 0, 0, 18'h0,     2, 0, 1, 0, 0, 18'h0,     0);
      tbl[4]  = mk(0, 0, 1, 0, 18'h0A000, 3, 0, 0, 0, 0, 18'h0,     0);
      tbl[5]  = mk(0, 0, 0, 0, 18'h0,     3, 0, 0, 0, 0, 18'h0,     0);
      tbl[6]  = mk(1, 0, 0, 0, 18'h0,     1, 1, 0, 0, 1, 18'h0A000, 0);
      tbl[7]  = mk(0, 1, 0, 0, 18'h0,     2, 0, 1, 0, 0, 18'h0A000, 0);
      tbl[8]  = mk(0, 0, 1, 0, 18'h3FFFF, 3, 0, 0, 0, 0, 18'h0A000, 0);
      tbl[9]  = mk(1, 0, 0, 0, 18'h0,     1, 1, 0, 0, 1, 18'h30000, 0);
      tbl[10] = mk(0, 1, 0, 0, 18'h0,     2, 0, 1, 0, 0, 18'h30000, 0);
      tbl[11] = mk(0, 0, 1, 0, 18'h12345, 3, 0, 0, 0, 0, 18'h30000, 0);
      tbl[12] = mk(1, 0, 0, 1, 18'h0,     4, 0, 0, 1, 1, 18'h0,     1);
      tbl[13] = mk(0, 0, 1, 0, 18'h3FFFF, 4, 0, 0, 0, 0, 18'h0,     1);
      for (int i = 0; i < 14; i++) begin
         bus.period_end = tbl[i].pe; bus.adc_done = tbl[i].ad; bus.pid_valid = tbl[i].pv;
         bus.current_high = tbl[i].ch; bus.pid_duty = tbl[i].pd;
         step();
         exp_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].as, tbl[i].pen, tbl[i].pclr,
                 tbl[i].dl, tbl[i].dc, tbl[i].f, 1'b0);
      end
      fault_len("cooldown", COOL - 1);   // two FAULT cycles already seen in the table

      // Enable loss mid-sample, then enable low in IDLE ignores period_end
      bus.period_end = 1'b1; step();
      chk("en_drop.sample", bus.state, 3'd1);
      bus.enable = 1'b0; step();
      exp_out("en_drop", 0, 0, 0, 1, 1, 18'h0, 0, 0);
      bus.period_end = 1'b1; step();
      exp_out("en_low_idle", 0, 0, 0, 0, 0, 18'h0, 0, 0);
      bus.enable = 1'b1;

      // ADC timeout: FAULT exactly 255 cycles after adc_start (retry 2)
      bus.period_end = 1'b1; step();
      n = 0;
      for (int i = 0; i < 254; i++) begin step(); if (bus.state == 3'd1) n++; end
      chk("adc_to.wait", n, 254);
      step();
      exp_out("adc_to", 4, 0, 0, 1, 1, 18'h0, 1, 0);
      fault_len("adc_to", COOL);

      // adc_done in the timeout cycle wins; then PID timeout (retry 3)
      bus.period_end = 1'b1; step();
      for (int i = 0; i < 254; i++) step();
      bus.adc_done = 1'b1; step();
      exp_out("adc_race", 2, 0, 1, 0, 0, 18'h0, 0, 0);
      n = 0;
      for (int i = 0; i < 62; i++) begin step(); if (bus.state == 3'd2) n++; end
      chk("pid_to.wait", n, 62);
      step();
      exp_out("pid_to", 4, 0, 0, 1, 1, 18'h0, 1, 0);
      fault_len("pid_to", COOL);

      // Fourth fault locks out; everything but clear_lockout is ignored
      trip("lock", 5);
      for (int i = 0; i < 5; i++) begin
         bus.period_end = 1'b1; bus.adc_done = 1'b1; bus.pid_valid = 1'b1;
         bus.current_high = 1'b1; bus.enable = i[0];
         step();
         chk("lock_hold.state", bus.state, 3'd5);
         chk("lock_hold.pulses", {bus.adc_start, bus.pid_en, bus.pid_clr, bus.duty_load}, 4'b0);
      end
      bus.enable = 1'b1;
      bus.clear_lockout = 1'b1; step();
      exp_out("clear", 0, 0, 0, 0, 0, 18'h0, 0, 0);

      // Retry decay: 2 faults, 16 clean loads, then 4 more faults to lock
      trip("decay_f1", 4); fault_len("decay_f1", COOL);
      trip("decay_f2", 4); fault_len("decay_f2", COOL);
      bus.period_end = 1'b1; step();
      for (int i = 0; i < 16; i++) begin
         bus.adc_done = 1'b1; step();
         bus.pid_valid = 1'b1; bus.pid_duty = 18'h100 + 18'(i); step();
         bus.period_end = 1'b1; step();
         chk($sformatf("decay_load%0d", i), {bus.duty_load, bus.adc_start, bus.duty_cmd},
             {1'b1, 1'b1, 18'h100 + 18'(i)});
      end
      trip("decay_f3", 4); fault_len("decay_f3", COOL);
      trip("decay_f4", 4); fault_len("decay_f4", COOL);
      trip("decay_f5", 4); fault_len("decay_f5", COOL);
      trip("decay_f6", 5);

      // Synchronous reset from LOCKOUT and mid-operation
      rst = 1'b1; step();
      exp_out("rst_lock", 0, 0, 0, 0, 0, 18'h0, 0, 0);
      rst = 1'b0;
      bus.period_end = 1'b1; step();
      bus.adc_done = 1'b1; step();
      bus.pid_valid = 1'b1; bus.pid_duty = 18'h02000; step();
      bus.period_end = 1'b1; step();
      chk("rst_mid.pre", bus.duty_cmd, 18'h02000);
      rst = 1'b1; bus.adc_done = 1'b1; step();
      exp_out("rst_mid", 0, 0, 0, 0, 0, 18'h0, 0, 0);
      rst = 1'b0;

      // Randomized run against a transaction-level model
      m_duty = '0; m_cool = 0; m_locked = 0; retries = 0; good = 0; pend.delete();
      pe_cnt = 3; adc_cd = 0; pid_cd = 0; lock_wait = 0; pid_val = '0;
      for (int cyc = 0; cyc < 6000; cyc++) begin
         pe = (pe_cnt == 0);
         if (pe) pe_cnt = $urandom_range(30, 60); else pe_cnt--;
         inj = !m_locked && (m_cool == 0) && !pe && ($urandom_range(0, 299) == 0);
         clr = m_locked && (lock_wait == 0);
         if (m_locked && lock_wait > 0) lock_wait--;
         if (inj) begin adc_cd = 0; pid_cd = 0; end
         ad = (adc_cd == 1); if (adc_cd > 0) adc_cd--;
         pv = (pid_cd == 1); if (pid_cd > 0) pid_cd--;
         bus.period_end = pe; bus.current_high = inj; bus.clear_lockout = clr;
         bus.adc_done = ad; bus.pid_valid = pv; bus.pid_duty = pid_val;

         e_as = 0; e_dl = 0; e_clr = 0;
         if (m_locked) begin
            if (clr) begin m_locked = 0; retries = 0; end
         end else if (m_cool > 0) begin
            m_cool--;
         end else if (inj) begin
            retries++; good = 0; pend.delete(); m_duty = '0; e_dl = 1; e_clr = 1;
            if (retries > MAXR) begin m_locked = 1; lock_wait = $urandom_range(3, 20); end
            else m_cool = COOL;
         end else if (pe) begin
            e_as = 1;
            if (pend.size() > 0) begin
               e_dl = 1; m_duty = pend.pop_front(); good++;
               if (good == GOODP) begin good = 0; retries = 0; end
            end
         end
         if (pv) pend.push_back((pid_val > DMAX) ? DMAX : pid_val);

         step();
         chk("rnd.adc_start", bus.adc_start, e_as);
         chk("rnd.duty_load", bus.duty_load, e_dl);
         chk("rnd.pid_clr",   bus.pid_clr, e_clr);
         chk("rnd.duty_cmd",  bus.duty_cmd, m_duty);
         chk("rnd.fault",     bus.fault, m_locked || (m_cool > 0));
         chk("rnd.lockout",   bus.lockout, m_locked);

         if (bus.adc_start) adc_cd = $urandom_range(1, 10);
         if (bus.pid_en) begin
            pid_cd = $urandom_range(1, 8);
            got = 18'($urandom);
            pid_val = got;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
